pe_block_n: RTL and testbench
=============================

Name: pe_block_n

Overview:
- Parametrised successor to the two-input ALU/MEM processing element.
- N input channels feed a per-operand input selector, with a programmable balancing delay line per operand, a multi-op ALU with accumulator, and a registered output carrying a valid bit.
- Configuration is a serial scan chain in the same clock domain, daisy-chained between PEs through config_in/config_out.

Parameters:
- SIZE, 32, datapath width in bits.
- NUM_IN, 4, number of input channels (2..8).
- DELAY_DEPTH, 4, maximum balancing delay per operand, in cycles (1..8).
- SEL_W, clog2(NUM_IN+1), width of an operand-select field (derived).
- DLY_W, clog2(DELAY_DEPTH+1), width of a delay field (derived).
- CFG_W, 2*SEL_W+2*DLY_W+4, total configuration bits (derived).

Ports:
- clk, input, 1, the single clock. Config shift and datapath both run on it.
- reset, input, 1, synchronous, active-high.
- config_en, input, 1, shift the config chain this cycle.
- config_in, input, 1, serial config bit in.
- config_out, output, 1, serial config bit out; equals cfg[0].
- in_data, input, NUM_IN*SIZE, flattened channels; channel k occupies bits [k*SIZE +: SIZE].
- in_valid, input, NUM_IN, per-channel valid.
- out0, output, SIZE, registered result.
- out_valid, output, 1, out0 holds a fresh result this cycle.

Behaviour:
- Interface rule (decided): one clock, clk; reset is synchronous and active-high, port name reset.
- Reset state: on reset, cfg, all delay stages, acc, out0 and out_valid all clear to 0. config_out = 0.
- Reset takes priority over config_en and data.
- Config chain: when config_en=1, cfg <= {config_in, cfg[CFG_W-1:1]} (LSB-first out).
  - Full load takes CFG_W cycles.
  - While config_en=1 the datapath freezes: delay lines, acc, out0 and out_valid hold, and out_valid is forced to 0.
- cfg fields, LSB upward:
  - sel_a[SEL_W]
  - sel_b[SEL_W]
  - dly_a[DLY_W]
  - dly_b[DLY_W]
  - op[4]
- Operand select:
  - sel < NUM_IN picks channel sel together with its in_valid.
  - sel == NUM_IN picks feedback: out0 with out_valid.
  - sel > NUM_IN gives data 0, valid 0.
- Delay lines:
  - Operand X passes through dly_X register stages, each carrying data and valid. dly_X=0 is combinational bypass.
  - dly_X > DELAY_DEPTH saturates to DELAY_DEPTH.
  - All stages shift every cycle, including bubbles with valid=0.
- Fire condition: fire = va & vb. For unary ops (PASSA, ACC) fire = va.
- ALU (combinational on the delayed operands a, b). Results are truncated to SIZE bits; arithmetic is unsigned modular.
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 MUL: low SIZE bits of a*b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL: a << (b mod SIZE)
  - 7 SHR: logical a >> (b mod SIZE)
  - 8 LTU: result 1 or 0
  - 9 EQ: result 1 or 0
  - 10 PASSA: a
  - 11 ACC: result = acc + a; acc <= acc + a on fire
  - 12 ACCCLR: result = a; acc <= a on fire (restart accumulation)
  - 13..15: result 0, fire treated as 0
- Output register: each non-frozen cycle, out_valid <= fire. On fire, out0 <= result; otherwise out0 holds.
- Latency: 1 + max(dly_a, dly_b) cycles from input valid to out_valid, when the delays are balanced for the source timing.
- Mismatched delays simply pair whatever arrives together. There is no stalling and no backpressure.
- Feedback loop: sel == NUM_IN with dly=0 yields a 1-cycle recurrence. For example ADD with both operands on feedback doubles out0 each cycle while out_valid=1.
- Reset mid-stream: in-flight tokens are dropped; out_valid=0 on the cycle after reset.

Decomposition:
- Shared package pe_pkg holds:
  - op encodings (OP_ADD..OP_ACCCLR)
  - cfg field offset/width functions of NUM_IN and DELAY_DEPTH
  - a clog2 function
- Sub-module pe_delay_line: parametrised SIZE+1-bit shift register, depth DELAY_DEPTH, runtime tap select, enable input (for freeze), synchronous reset. Instantiated twice.
- The ALU stays inline.

Test Plan:
- Config scan: reset, then shift CFG_W bits encoding sel_a=0, sel_b=1, dly=0/0, op=ADD; then shift CFG_W more zeros. Required: config_out reproduces the first pattern LSB-first, delayed CFG_W cycles.
- Basic ADD: cfg as above, in0=5, in1=7, both valid for one cycle. Required: out0=12, out_valid=1 exactly one cycle later, then out_valid=0 with out0 still 12.
- Delay balancing: sel_a=2, sel_b=3, dly_a=3, dly_b=1, op=SUB. Drive ch2=100 at cycle t and ch3=40 at cycle t+2. Required: out0=60, out_valid=1 at t+4.
- Accumulate: op=ACCCLR with a=10 fired once, then op reloaded to ACC, then a=1,2,3 on consecutive cycles. Required: out0 = 11, 13, 16; SIZE wrap verified with 0xFFFFFFFF+1 giving 0.
- Feedback and freeze: sel_a=sel_b=NUM_IN, op=ADD, seeded out0=1 via PASSA. Required: 2, 4, 8 on successive cycles. Asserting config_en for 3 cycles holds out0 and forces out_valid=0.
- Reset mid-operation: dly_a=dly_b=4 with tokens in flight, assert reset 1 cycle. Required: out_valid stays 0 for the next 5 cycles, out0=0, config_out=0.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared op encodings and config field layout helpers for pe_block_n
package pe_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_SHL    = 4'd6,
        OP_SHR    = 4'd7,
        OP_LTU    = 4'd8,
        OP_EQ     = 4'd9,
        OP_PASSA  = 4'd10,
        OP_ACC    = 4'd11,
        OP_ACCCLR = 4'd12
    } pe_op_e;

    localparam int OP_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int sel_w(input int num_in);
        return clog2(num_in + 1);
    endfunction

    function automatic int dly_w(input int depth);
        return clog2(depth + 1);
    endfunction

    // Layout, LSB upward: sel_a, sel_b, dly_a, dly_b, op
    function automatic int off_sel_b(input int num_in);
        return sel_w(num_in);
    endfunction

    function automatic int off_dly_a(input int num_in);
        return 2 * sel_w(num_in);
    endfunction

    function automatic int off_dly_b(input int num_in, input int depth);
        return 2 * sel_w(num_in) + dly_w(depth);
    endfunction

    function automatic int off_op(input int num_in, input int depth);
        return 2 * sel_w(num_in) + 2 * dly_w(depth);
    endfunction

    function automatic int cfg_w(input int num_in, input int depth);
        return off_op(num_in, depth) + OP_W;
    endfunction

endpackage

// File: rtl/pe_block_n_delay_line.sv
// rtl/pe_block_n_delay_line.sv - freezable shift register with runtime tap select (pe_delay_line)
module pe_delay_line #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int TAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [TAP_W-1:0] tap,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     out_data
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;
    logic [TAP_W-1:0]        tap_sat;

    // Shift every enabled cycle, bubbles included, so token spacing is preserved
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Tap 0 is a combinational bypass; taps beyond the line saturate to the last stage
    always_comb begin
        tap_sat  = (tap > TAP_W'(DEPTH)) ? TAP_W'(DEPTH) : tap;
        out_data = in_data;
        for (int k = 1; k <= DEPTH; k++) begin
            if (tap_sat == TAP_W'(k)) out_data = stage_q[k-1];
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (reset) stage_q <= '0;
        else       stage_q <= stage_d;
    end

endmodule

// File: rtl/pe_block_n.sv
// rtl/pe_block_n.sv - N-input processing element with operand select, delay balancing, ALU and accumulator
module pe_block_n
    import pe_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int NUM_IN      = 4,
    parameter int DELAY_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   config_en,
    input  logic                   config_in,
    output logic                   config_out,
    input  logic [NUM_IN*SIZE-1:0] in_data,
    input  logic [NUM_IN-1:0]      in_valid,
    output logic [SIZE-1:0]        out0,
    output logic                   out_valid
);

    localparam int SEL_W = sel_w(NUM_IN);
    localparam int DLY_W = dly_w(DELAY_DEPTH);
    localparam int CFG_W = cfg_w(NUM_IN, DELAY_DEPTH);
    localparam int O_SB  = off_sel_b(NUM_IN);
    localparam int O_DA  = off_dly_a(NUM_IN);
    localparam int O_DB  = off_dly_b(NUM_IN, DELAY_DEPTH);
    localparam int O_OP  = off_op(NUM_IN, DELAY_DEPTH);
    localparam logic [SIZE-1:0] SIZE_V = SIZE'(SIZE);

    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [SIZE-1:0]  acc_q, acc_d;
    logic [SIZE-1:0]  out0_q, out0_d;
    logic             out_valid_q, out_valid_d;

    logic [SEL_W-1:0] sel_a, sel_b;
    logic [DLY_W-1:0] dly_a, dly_b;
    logic [OP_W-1:0]  op;
    logic [SIZE:0]    a_src, b_src, a_dly, b_dly;
    logic [SIZE-1:0]  a, b, shamt, result;
    logic             va, vb, fire;

    assign sel_a = cfg_q[0    +: SEL_W];
    assign sel_b = cfg_q[O_SB +: SEL_W];
    assign dly_a = cfg_q[O_DA +: DLY_W];
    assign dly_b = cfg_q[O_DB +: DLY_W];
    assign op    = cfg_q[O_OP +: OP_W];

    // Channel k, feedback at NUM_IN, anything above is an idle operand
    function automatic logic [SIZE:0] pick(input logic [SEL_W-1:0]       sel,
                                           input logic [NUM_IN*SIZE-1:0] d,
                                           input logic [NUM_IN-1:0]      v,
                                           input logic [SIZE-1:0]        fb,
                                           input logic                   fbv);
        pick = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) pick = {v[k], d[k*SIZE +: SIZE]};
        end
        if (sel == SEL_W'(NUM_IN)) pick = {fbv, fb};
    endfunction

    // Operand selection ahead of the delay lines
    always_comb begin
        a_src = pick(sel_a, in_data, in_valid, out0_q, out_valid_q);
        b_src = pick(sel_b, in_data, in_valid, out0_q, out_valid_q);
    end

    pe_delay_line #(.W(SIZE + 1), .DEPTH(DELAY_DEPTH), .TAP_W(DLY_W)) u_dly_a (
        .clk(clk), .reset(reset), .en(!config_en), .tap(dly_a), .in_data(a_src), .out_data(a_dly)
    );

    pe_delay_line #(.W(SIZE + 1), .DEPTH(DELAY_DEPTH), .TAP_W(DLY_W)) u_dly_b (
        .clk(clk), .reset(reset), .en(!config_en), .tap(dly_b), .in_data(b_src), .out_data(b_dly)
    );

    // ALU and fire decision on the delayed operands
    always_comb begin
        a      = a_dly[SIZE-1:0];
        b      = b_dly[SIZE-1:0];
        va     = a_dly[SIZE];
        vb     = b_dly[SIZE];
        shamt  = b % SIZE_V;
        result = '0;
        fire   = va & vb;
        case (op)
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_MUL:    result = a * b;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_SHL:    result = a << shamt;
            OP_SHR:    result = a >> shamt;
            OP_LTU:    result = {{(SIZE-1){1'b0}}, (a < b)};
            OP_EQ:     result = {{(SIZE-1){1'b0}}, (a == b)};
            OP_PASSA:  begin result = a;         fire = va; end
            OP_ACC:    begin result = acc_q + a; fire = va; end
            OP_ACCCLR: begin result = a;         fire = va; end
            default:   begin result = '0;        fire = 1'b0; end
        endcase
    end

    // Next state: config shift freezes the datapath, otherwise register the ALU outcome
    always_comb begin
        cfg_d       = cfg_q;
        acc_d       = acc_q;
        out0_d      = out0_q;
        out_valid_d = out_valid_q;
        if (config_en) begin
            cfg_d = {config_in, cfg_q[CFG_W-1:1]};
        end else begin
            out_valid_d = fire;
            if (fire) begin
                out0_d = result;
                if (op == OP_ACC)    acc_d = acc_q + a;
                if (op == OP_ACCCLR) acc_d = a;
            end
        end
    end

    // State registers; reset wins over config and data
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q       <= '0;
            acc_q       <= '0;
            out0_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            acc_q       <= acc_d;
            out0_q      <= out0_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Held valid is masked while frozen so a feedback loop resumes after reconfiguration
    assign out_valid  = out_valid_q & ~config_en;
    assign out0       = out0_q;
    assign config_out = cfg_q[0];

endmodule

// File: tb/tb_pe_block_n.sv
// tb/tb_pe_block_n.sv - directed self-checking bench for pe_block_n
module tb_pe_block_n;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         config_en = 1'b0;
    logic         config_in = 1'b0;
    logic         config_out;
    logic [127:0] in_data = '0;
    logic [3:0]   in_valid = '0;
    logic [31:0]  out0;
    logic         out_valid;

    int vectors = 0;
    int miscompares = 0;

    pe_block_n #(.SIZE(32), .NUM_IN(4), .DELAY_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
        .config_out(config_out), .in_data(in_data), .in_valid(in_valid),
        .out0(out0), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] mk(input int sa, input int sb, input int da, input int db, input int op);
        logic [15:0] v;
        v[2:0]   = 3'(sa);
        v[5:3]   = 3'(sb);
        v[8:6]   = 3'(da);
        v[11:9]  = 3'(db);
        v[15:12] = 4'(op);
        return v;
    endfunction

    task automatic load(input logic [15:0] v);
        in_valid = '0;
        for (int i = 0; i < 16; i++) begin
            config_en = 1'b1;
            config_in = v[i];
            step();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        in_data[k*32 +: 32] = v;
    endtask

    logic [15:0] p1;
    logic [15:0] cap;
    int          ops_op [9]  = '{2, 3, 4, 5, 6, 7, 8, 9, 13};
    logic [31:0] ops_a  [9]  = '{32'd6, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h8000_0000, 32'd3, 32'd5, 32'd9};
    logic [31:0] ops_b  [9]  = '{32'd7, 32'hFF00, 32'hFF00, 32'hFF00, 32'd36, 32'd33, 32'd5, 32'd5, 32'd9};
    logic [31:0] ops_r  [9]  = '{32'd42, 32'hF000, 32'hFFF0, 32'h0FF0, 32'h10, 32'h4000_0000, 32'd1, 32'd1, 32'd1};
    logic        ops_v  [9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        #1;
        // Reset state
        do_reset();
        chk("reset_out0", out0, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_cfg_out", {31'd0, config_out}, 32'd0);

        // Config scan: pattern reappears LSB-first on config_out
        p1 = mk(0, 1, 0, 0, 0);
        load(p1);
        for (int i = 0; i < 16; i++) begin
            cap[i]    = config_out;
            config_en = 1'b1;
            config_in = 1'b0;
            step();
        end
        config_en = 1'b0;
        chk("scan_pattern", {16'd0, cap}, {16'd0, p1});
        chk("scan_flushed", {31'd0, config_out}, 32'd0);

        // Basic ADD
        load(p1);
        set_ch(0, 32'd5);
        set_ch(1, 32'd7);
        in_valid = 4'b0011;
        step();
        in_valid = '0;
        chk("add_out0", out0, 32'd12);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("add_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("add_out0_hold", out0, 32'd12);

        // Delay balancing: ch2 at t, ch3 at t+2, result visible at t+4
        do_reset();
        load(mk(2, 3, 3, 1, 1));
        set_ch(2, 32'd100);
        in_valid = 4'b0100;
        step();
        in_valid = '0;
        step();
        set_ch(3, 32'd40);
        in_valid = 4'b1000;
        step();
        in_valid = '0;
        chk("dly_early_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("dly_out0", out0, 32'd60);
        chk("dly_valid", {31'd0, out_valid}, 32'd1);

        // Accumulate
        do_reset();
        load(mk(0, 7, 0, 0, 12));
        set_ch(0, 32'd10);
        in_valid = 4'b0001;
        step();
        chk("accclr_out0", out0, 32'd10);
        load(mk(0, 7, 0, 0, 11));
        in_valid = 4'b0001;
        set_ch(0, 32'd1);
        step();
        chk("acc_11", out0, 32'd11);
        set_ch(0, 32'd2);
        step();
        chk("acc_13", out0, 32'd13);
        set_ch(0, 32'd3);
        step();
        chk("acc_16", out0, 32'd16);
        load(mk(0, 7, 0, 0, 12));
        set_ch(0, 32'hFFFF_FFFF);
        in_valid = 4'b0001;
        step();
        chk("accclr_max", out0, 32'hFFFF_FFFF);
        load(mk(0, 7, 0, 0, 11));
        set_ch(0, 32'd1);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        chk("acc_wrap", out0, 32'd0);
        chk("acc_wrap_valid", {31'd0, out_valid}, 32'd1);

        // Remaining binary ops, then a reserved op that must not fire
        do_reset();
        for (int i = 0; i < 9; i++) begin
            load(mk(0, 1, 0, 0, ops_op[i]));
            set_ch(0, ops_a[i]);
            set_ch(1, ops_b[i]);
            in_valid = 4'b0011;
            step();
            in_valid = '0;
            chk($sformatf("op%0d_out0", ops_op[i]), out0, ops_r[i]);
            chk($sformatf("op%0d_valid", ops_op[i]), {31'd0, out_valid}, {31'd0, ops_v[i]});
        end

        // Feedback doubling and freeze
        do_reset();
        load(mk(0, 7, 0, 0, 10));
        set_ch(0, 32'd1);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        chk("seed_out0", out0, 32'd1);
        load(mk(4, 4, 0, 0, 0));
        step();
        chk("fb_2", out0, 32'd2);
        step();
        chk("fb_4", out0, 32'd4);
        step();
        chk("fb_8", out0, 32'd8);
        chk("fb_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            config_en = 1'b1;
            step();
            chk($sformatf("freeze%0d_valid", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("freeze%0d_out0", i), out0, 32'd8);
        end
        config_en = 1'b0;

        // Reset with tokens in flight
        do_reset();
        load(mk(0, 1, 4, 4, 0));
        set_ch(0, 32'd3);
        set_ch(1, 32'd4);
        in_valid = 4'b0011;
        step();
        step();
        in_valid = '0;
        step();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_mid_valid%0d", i), {31'd0, out_valid}, 32'd0);
            step();
        end
        chk("rst_mid_out0", out0, 32'd0);
        chk("rst_mid_cfg_out", {31'd0, config_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
